// File: rtl/rof_sequencer_pkg.sv
// rof_sequencer_pkg: state encoding and default parameters for the rank-order filter run controller
package rof_sequencer_pkg;
  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_ISSUE, S_DRAIN, S_DONE} state_t;
  localparam int DEF_N = 9;
  localparam int DEF_ADDR_BITS = 8;
  localparam int DEF_NUM_SAMPLES = 255;
  localparam int DEF_ROM_LAT = 1;
  localparam int DEF_FILT_LAT = 1;
endpackage

// File: rtl/rof_sequencer_if.sv
// rof_sequencer_if: run-control and ROM/filter/RAM sequencing signals of the rank-order filter
interface rof_sequencer_if
  import rof_sequencer_pkg::*;
#(
  parameter int ADDR_BITS = DEF_ADDR_BITS
);
  logic start, hold, filt_clr, filt_en, ram_we, busy, done;
  logic [ADDR_BITS-1:0] rom_addr, ram_waddr;
  modport master (output start, hold, input rom_addr, filt_clr, filt_en, ram_we, ram_waddr, busy, done);
  modport slave (input start, hold, output rom_addr, filt_clr, filt_en, ram_we, ram_waddr, busy, done);
endinterface

// File: rtl/rof_sequencer_valid_delay.sv
// valid_delay: shift register of valid bits; pend flags any bit held after the coming edge
module valid_delay #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic pend
);
  logic [DEPTH-1:0] sr, sr_n;
  assign sr_n = DEPTH'({sr, din});
  assign dout = sr[DEPTH-1];
  assign pend = |sr_n;
  always_ff @(posedge clk) sr <= rst ? '0 : sr_n;
endmodule

// File: rtl/rof_sequencer.sv
// rof_sequencer: sequences ROM reads, filter enables and result RAM writes for one filter run
module rof_sequencer
  import rof_sequencer_pkg::*;
#(
  parameter int N           = DEF_N,
  parameter int ADDR_BITS   = DEF_ADDR_BITS,
  parameter int NUM_SAMPLES = DEF_NUM_SAMPLES,
  parameter int ROM_LAT     = DEF_ROM_LAT,
  parameter int FILT_LAT    = DEF_FILT_LAT
) (
  input logic clk,
  input logic rst,
  rof_sequencer_if.slave bus
);
  if (N < 1 || NUM_SAMPLES < 1 || NUM_SAMPLES >= 2**ADDR_BITS || ROM_LAT < 1 || FILT_LAT < 1) begin : g_bad_cfg
    $error("rof_sequencer: illegal parameter set");
  end
  state_t state, state_n;
  logic [ADDR_BITS-1:0] cnt, waddr;
  logic issue, last, rom_vld, rom_pend, wr_vld, wr_pend;
  assign issue = state == S_ISSUE && !bus.hold;
  assign last = cnt == ADDR_BITS'(NUM_SAMPLES - 1);
  valid_delay #(.DEPTH(ROM_LAT)) u_rom_dly (.clk(clk), .rst(rst), .din(issue), .dout(rom_vld), .pend(rom_pend));
  valid_delay #(.DEPTH(FILT_LAT)) u_filt_dly (.clk(clk), .rst(rst), .din(rom_vld), .dout(wr_vld), .pend(wr_pend));
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  state_n = bus.start ? S_CLEAR : S_IDLE;
      S_CLEAR: state_n = S_ISSUE;
      S_ISSUE: state_n = issue && last ? S_DRAIN : S_ISSUE;
      // leave on the edge that empties the pipes, so done lands right after the last write
      S_DRAIN: state_n = rom_pend || wr_pend ? S_DRAIN : S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    bus.filt_clr = state == S_CLEAR;
    bus.filt_en = rom_vld;
    bus.ram_we = wr_vld;
    bus.busy = state == S_CLEAR || state == S_ISSUE || state == S_DRAIN;
    bus.done = state == S_DONE;
    bus.rom_addr = cnt;
    bus.ram_waddr = waddr;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt <= '0;
      waddr <= '0;
    end else begin
      state <= state_n;
      cnt <= state_n == S_CLEAR ? '0 : issue && !last ? cnt + 1'b1 : cnt;
      waddr <= state_n == S_CLEAR ? '0 : wr_vld ? waddr + 1'b1 : waddr;
    end
  end
endmodule
